// File: rtl/fft_result_reader.sv
// Drains four FFT magnitude buffers in fixed order 0,1,2,3 onto a ready/valid stream.
// Reads are throttled so the 2-entry output buffer never overflows.
module fft_result_reader #(
  parameter int unsigned N_POINTS = 1024,
  parameter int unsigned DATA_W   = 17,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [3:0]        fft_done_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [3:0]        rd_en_o,
  input  logic [DATA_W-1:0] rd_data_0_i,
  input  logic [DATA_W-1:0] rd_data_1_i,
  input  logic [DATA_W-1:0] rd_data_2_i,
  input  logic [DATA_W-1:0] rd_data_3_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sop_o,
  output logic              out_eop_o,
  output logic [1:0]        out_fft_id_o,
  output logic [3:0]        release_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_POINTS - 1);

  typedef enum logic {StIdle, StRead} state_e;

  state_e              state_q;
  logic [1:0]          next_id_q;
  logic [3:0]          pending_q, busy_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [3:0]          rd_en_q;
  logic [1:0]          rd_id_q;
  logic                rd_sop_q, rd_eop_q;
  logic                ret_q;
  logic [1:0]          ret_id_q;
  logic                ret_sop_q, ret_eop_q;
  logic [DATA_W-1:0]   fifo_data_q [2];
  logic [1:0]          fifo_id_q   [2];
  logic                fifo_sop_q  [2];
  logic                fifo_eop_q  [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          cnt_q, cnt_d;
  logic [3:0]          release_q, release_d;
  logic                overflow_q;

  logic [DATA_W-1:0]   ret_data, head_data;
  logic [1:0]          head_id;
  logic                head_sop, head_eop, head_valid;
  logic                accept, push, pop, can_issue, start, issue, last;
  logic [3:0]          pend_all, id_onehot;
  logic [ADDR_W-1:0]   next_addr;

  always_comb begin
    unique case (ret_id_q)
      2'd0:    ret_data = rd_data_0_i;
      2'd1:    ret_data = rd_data_1_i;
      2'd2:    ret_data = rd_data_2_i;
      default: ret_data = rd_data_3_i;
    endcase
    // Returning read data bypasses the buffer when it is empty.
    if (cnt_q != 2'd0) begin
      head_data = fifo_data_q[rd_ptr_q];
      head_id   = fifo_id_q[rd_ptr_q];
      head_sop  = fifo_sop_q[rd_ptr_q];
      head_eop  = fifo_eop_q[rd_ptr_q];
    end else begin
      head_data = ret_data;
      head_id   = ret_id_q;
      head_sop  = ret_sop_q;
      head_eop  = ret_eop_q;
    end
    head_valid = (cnt_q != 2'd0) | ret_q;
    accept     = head_valid & out_ready_i;
    push       = ret_q & ~((cnt_q == 2'd0) & accept);
    pop        = (cnt_q != 2'd0) & accept;
    cnt_d      = cnt_q + 2'(push) - 2'(pop);
    // Occupancy after this edge plus the read still in flight must leave room.
    can_issue  = (cnt_d + 2'(|rd_en_q)) < 2'd2;
    pend_all   = pending_q | fft_done_i;
    id_onehot  = 4'b0001 << next_id_q;
    start      = (state_q == StIdle) & pend_all[next_id_q] & can_issue;
    issue      = start | ((state_q == StRead) & can_issue);
    next_addr  = start ? '0 : rd_addr_q + 1'b1;
    last       = (next_addr == LastAddr);
    release_d  = (accept & head_eop) ? (4'b0001 << head_id) : 4'b0000;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      next_id_q  <= 2'd0;
      pending_q  <= 4'b0;
      busy_q     <= 4'b0;
      rd_addr_q  <= '0;
      rd_en_q    <= 4'b0;
      rd_id_q    <= 2'd0;
      rd_sop_q   <= 1'b0;
      rd_eop_q   <= 1'b0;
      ret_q      <= 1'b0;
      ret_id_q   <= 2'd0;
      ret_sop_q  <= 1'b0;
      ret_eop_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= 2'd0;
        fifo_sop_q[i]  <= 1'b0;
        fifo_eop_q[i]  <= 1'b0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      release_q  <= 4'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pend_all & ~(id_onehot & {4{start}});
      busy_q     <= (busy_q & ~release_d) | (id_onehot & {4{start}});
      overflow_q <= overflow_q | (|(fft_done_i & (pending_q | busy_q)));
      release_q  <= release_d;
      rd_en_q    <= issue ? id_onehot : 4'b0;
      if (issue) begin
        rd_addr_q <= next_addr;
        rd_id_q   <= next_id_q;
        rd_sop_q  <= (next_addr == '0);
        rd_eop_q  <= last;
        if (last) begin
          state_q   <= StIdle;
          next_id_q <= next_id_q + 2'd1;
        end else begin
          state_q   <= StRead;
        end
      end
      ret_q     <= |rd_en_q;
      ret_id_q  <= rd_id_q;
      ret_sop_q <= rd_sop_q;
      ret_eop_q <= rd_eop_q;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ret_data;
        fifo_id_q[wr_ptr_q]   <= ret_id_q;
        fifo_sop_q[wr_ptr_q]  <= ret_sop_q;
        fifo_eop_q[wr_ptr_q]  <= ret_eop_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign rd_addr_o    = rd_addr_q;
  assign rd_en_o      = rd_en_q;
  assign out_valid_o  = head_valid;
  assign out_data_o   = head_valid ? head_data : '0;
  assign out_sop_o    = head_valid & head_sop;
  assign out_eop_o    = head_valid & head_eop;
  assign out_fft_id_o = head_valid ? head_id : 2'd0;
  assign release_o    = release_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader: latency, ordering, backpressure, overflow, reset abort.
module tb_fft_result_reader;
  localparam int NP = 1024;
  localparam int DW = 17;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    fft_done;
  logic [AW-1:0] rd_addr;
  logic [3:0]    rd_en;
  logic [DW-1:0] rd_data [4];
  logic          out_valid, out_ready, out_sop, out_eop, overflow;
  logic [DW-1:0] out_data;
  logic [1:0]    out_fft_id;
  logic [3:0]    release_p;

  fft_result_reader #(.N_POINTS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .reset_i(reset), .fft_done_i(fft_done),
    .rd_addr_o(rd_addr), .rd_en_o(rd_en),
    .rd_data_0_i(rd_data[0]), .rd_data_1_i(rd_data[1]),
    .rd_data_2_i(rd_data[2]), .rd_data_3_i(rd_data[3]),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_sop_o(out_sop), .out_eop_o(out_eop), .out_fft_id_o(out_fft_id),
    .release_o(release_p), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_val(int k, int a);
    return DW'((k << 15) | ((a * 5 + 3) & 32'h7fff));
  endfunction

  // Synchronous-read buffer model: data appears the cycle after rd_en.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rd_en[k]) rd_data[k] <= mem_val(k, int'(rd_addr));
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [1:0]    id;
    int            cyc;
  } smp_t;
  typedef struct packed {
    logic [3:0] val;
    int         cyc;
  } rel_t;

  smp_t samples[$];
  rel_t rels[$];
  int   rd_cnt = 0;
  int   stall_err = 0;
  bit   prev_stall = 0;
  smp_t prev_s;

  always @(negedge clk) begin
    smp_t s;
    if (reset) begin
      prev_stall = 0;
    end else begin
      s = '{data: out_data, sop: out_sop, eop: out_eop, id: out_fft_id, cyc: cyc};
      if (prev_stall && (!out_valid || s.data !== prev_s.data || s.sop !== prev_s.sop ||
                         s.eop !== prev_s.eop || s.id !== prev_s.id)) stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_s     = s;
      if (out_valid && out_ready) samples.push_back(s);
      if (release_p != 4'b0) rels.push_back('{val: release_p, cyc: cyc});
      if (rd_en != 4'b0) rd_cnt++;
    end
  end

  int n_pass = 0;
  int n_chk  = 0;
  bit rnd_ready = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [3:0] v);
    fft_done = v;
    tick();
    fft_done = 4'b0;
  endtask

  task automatic wait_samples(input string tag, input int n, input int budget);
    int b = 0;
    while (samples.size() < n && b < budget) begin
      tick();
      b++;
    end
    check(tag, 32'(samples.size() >= n), 1);
  endtask

  task automatic check_frame(input string tag, input int k, output int first, output int last);
    int   nerr = 0;
    smp_t s;
    first = -1;
    last  = -1;
    for (int i = 0; i < NP; i++) begin
      if (samples.size() == 0) begin
        nerr++;
        break;
      end
      s = samples.pop_front();
      if (i == 0) first = s.cyc;
      if (i == NP - 1) last = s.cyc;
      if (s.data !== mem_val(k, i) || s.sop !== (i == 0) || s.eop !== (i == NP - 1) ||
          s.id !== 2'(k)) nerr++;
    end
    check(tag, nerr, 0);
  endtask

  task automatic get_release(output logic [3:0] v, output int c);
    rel_t r;
    r = (rels.size() > 0) ? rels.pop_front() : '0;
    v = r.val;
    c = r.cyc;
  endtask

  initial begin
    int c0, f0, l0, f1, l1, rc;
    logic [3:0] rv;

    reset     = 1'b1;
    fft_done  = 4'b0;
    out_ready = 1'b1;
    ticks(3);
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_release", release_p, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_addr", rd_addr, 0);
    reset = 1'b0;
    ticks(5);

    // Single frame 0: latency and full content.
    c0 = cyc;
    pulse(4'b0001);
    check("lat_rd_en", rd_en, 4'b0001);
    check("lat_rd_addr", rd_addr, 0);
    check("lat_no_valid_yet", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_sop", out_sop, 1);
    check("lat_id", out_fft_id, 0);
    check("lat_data", out_data, mem_val(0, 0));
    wait_samples("f0_wait", NP, NP + 100);
    check_frame("f0_content", 0, f0, l0);
    check("f0_first_cyc", f0, c0 + 2);
    check("f0_eop_cyc", l0, c0 + NP + 1);
    ticks(2);
    get_release(rv, rc);
    check("f0_release", rv, 4'b0001);
    check("f0_release_cyc", rc, c0 + NP + 2);

    // Out-of-order done: FFT 1 waits for FFT 0, then both stream back-to-back.
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    samples.delete();
    rels.delete();
    c0 = rd_cnt;
    pulse(4'b0010);
    ticks(20);
    check("ooo_no_read", rd_cnt - c0, 0);
    check("ooo_no_sample", samples.size(), 0);
    pulse(4'b0001);
    wait_samples("b2b_wait", 2 * NP, 2 * NP + 100);
    check_frame("b2b_f0", 0, f0, l0);
    check_frame("b2b_f1", 1, f1, l1);
    check("b2b_no_gap", f1, l0 + 1);
    ticks(2);
    get_release(rv, rc);
    check("b2b_rel0", rv, 4'b0001);
    get_release(rv, rc);
    check("b2b_rel1", rv, 4'b0010);

    // Frame 2 under random backpressure.
    rnd_ready = 1;
    c0 = stall_err;
    pulse(4'b0100);
    wait_samples("bp_wait", NP, 6 * NP);
    rnd_ready = 0;
    check_frame("bp_f2", 2, f0, l0);
    check("bp_stable", stall_err - c0, 0);
    ticks(3);
    get_release(rv, rc);
    check("bp_rel2", rv, 4'b0100);

    // Simultaneous done for 3 and 0: served as 3 then 0, wrapping next_id.
    pulse(4'b1001);
    wait_samples("wrap_wait", 2 * NP, 2 * NP + 100);
    check_frame("wrap_f3", 3, f0, l0);
    check_frame("wrap_f0", 0, f1, l1);
    check("wrap_no_gap", f1, l0 + 1);
    check("wrap_no_overflow", overflow, 0);
    ticks(2);
    get_release(rv, rc);
    check("wrap_rel3", rv, 4'b1000);
    get_release(rv, rc);
    check("wrap_rel0", rv, 4'b0001);

    // Reset in the middle of frame 1.
    samples.delete();
    rels.delete();
    pulse(4'b0010);
    wait_samples("abort_wait", 500, 700);
    reset = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_data", out_data, 0);
    check("abort_eop", out_eop, 0);
    check("abort_release", release_p, 0);
    ticks(2);
    reset = 1'b0;
    ticks(3);
    check("abort_no_release", rels.size(), 0);

    // Restart at FFT 0, then a second done[0] mid-read raises sticky overflow.
    samples.delete();
    pulse(4'b0001);
    ticks(100);
    check("ovf_before", overflow, 0);
    pulse(4'b0001);
    check("ovf_set", overflow, 1);
    wait_samples("ovf_wait", NP, NP + 100);
    check_frame("ovf_f0", 0, f0, l0);
    c0 = rd_cnt;
    ticks(50);
    check("ovf_sticky", overflow, 1);
    check("ovf_pending0_ignored", rd_cnt - c0, 0);
    reset = 1'b1;
    #1;
    check("ovf_cleared", overflow, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_result_reader.md
FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 SHALL have parameter N_POINTS, default 1024, giving samples per FFT result buffer.
REQ-002 SHALL have parameter DATA_W, default 17, giving the magnitude sample width.
REQ-003 SHALL have parameter ADDR_W, default 10, giving the buffer address width; clog2(N_POINTS).
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port fft_done  in  4  one-cycle pulse per FFT k: result buffer k is complete.
REQ-007 SHALL have port rd_addr  out  ADDR_W  shared read address to all four result buffers.
REQ-008 SHALL have port rd_en  out  4  one-hot read strobe; buffer returns data one cycle later.
REQ-009 SHALL have ports rd_data_0..rd_data_3  in  DATA_W each  read data from buffers 0..3.
REQ-010 SHALL have port out_valid  out  1  output sample valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts the sample when valid and ready are both high.
REQ-012 SHALL have port out_data  out  DATA_W  magnitude sample.
REQ-013 SHALL have ports out_sop/out_eop  out  1 each  high on sample index 0 / index N_POINTS-1.
REQ-014 SHALL have port out_fft_id  out  2  source FFT of the current sample.
REQ-015 SHALL have port release  out  4  one-cycle pulse: buffer k fully read, writer may refill it.
REQ-016 SHALL have port overflow  out  1  sticky error flag.

Function
REQ-017 SHALL hold a pending bit per FFT; fft_done[k] sets pending[k].
REQ-018 SHALL serve buffers in strict order 0,1,2,3,0,... via next_id, matching the writer's fill order; the pending bit of any other k SHALL be ignored until that k becomes next_id.
REQ-019 SHALL implement FSM states IDLE and READ.
REQ-020 IDLE -> READ when pending[next_id]=1 (including the same edge fft_done sets it): clear pending[next_id], set rd_addr=0.
REQ-021 Latency: fft_done[next_id] high in cycle c, idle FSM -> rd_en[next_id] high in cycle c+1, first out_valid in cycle c+2.
REQ-022 In READ, SHALL issue a read only while (occupied output buffer entries + reads in flight) < 2; rd_addr increments per issued read.
REQ-023 SHALL use a 2-entry output buffer so that, with out_ready held high, one sample per cycle is delivered with no gaps.
REQ-024 out_data, out_sop, out_eop, out_fft_id SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 After issuing address N_POINTS-1, SHALL leave READ for IDLE and advance next_id modulo 4 (3 wraps to 0).
REQ-026 release[k] SHALL pulse in the cycle after the handshake of the out_eop sample of buffer k.
REQ-027 A new FSM read MAY start before the previous frame drains; output order SHALL remain sample order.
REQ-028 fft_done[k] while pending[k]=1, or while buffer k is being read and not yet released, SHALL set overflow; pending[k] stays 1 without double-counting.
REQ-029 Multiple fft_done bits in the same cycle SHALL all be recorded.

Reset
REQ-030 While reset is high: state IDLE, next_id=0, pending=0, buffer empty, rd_addr=0, rd_en=0, out_valid=0, out_data=0, out_sop=0, out_eop=0, out_fft_id=0, release=0, overflow=0.
REQ-031 Reset mid-frame SHALL abort immediately with no release pulse; after deassertion, service restarts at FFT 0.

Verification
REQ-032 fft_done=0001 in cycle 10, out_ready=1 -> rd_en=0001 in cycle 11, out_sop with out_fft_id=0 in cycle 12, out_eop in cycle 1035, release=0001 in cycle 1036.
REQ-033 fft_done[1] before fft_done[0] -> no reads until fft_done[0]; then frame 0 fully, then frame 1, back-to-back with no idle cycle at out_ready=1.
REQ-034 Random out_ready at 50% -> all 1024 samples of buffer 2 delivered in address order, no loss or duplication, outputs stable during stall.
REQ-035 Frames for ids 0,1,2,3,0 -> out_fft_id sequence 0,1,2,3,0; next_id wraps from 3 to 0.
REQ-036 Second fft_done[0] while frame 0 is mid-read -> overflow=1 and remains 1 until reset.
REQ-037 reset asserted at sample 500 of frame 1 -> all outputs 0 asynchronously, no release; next fft_done=0001 produces an out_fft_id=0 frame.
